// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU constants, writeback buffer entry type, rd decode helper
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NREG       = 32;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  typedef struct packed {
    logic                  full;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // $0 decodes to an all-zero select so writes to it never reach the file
  function automatic logic [NREG-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = '0;
    if (rd != '0) rd_onehot[rd] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_buf.sv
// ============================================================================
// Module : rf_wb_buf
// Brief  : One-entry writeback input buffer with registered ready
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_wb_buf
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_grant,
  output logic                  o_ready,
  output logic                  o_full,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0]     o_data
);

  wb_entry_t r_entry;

  // Accept only while empty and grant only while full, so the two never collide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entry <= '0;
    end else if (i_valid && !r_entry.full) begin
      r_entry.full <= 1'b1;
      r_entry.rd   <= i_rd;
      r_entry.data <= i_data;
    end else if (i_grant) begin
      r_entry.full <= 1'b0;
    end
  end

  assign o_ready = !r_entry.full;
  assign o_full  = r_entry.full;
  assign o_rd    = r_entry.rd;
  assign o_data  = r_entry.data;

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Two-port register-file write arbiter with one-hot Dselect output.
//          RF_WB_ARB_RR_EN selects round-robin; otherwise port 0 has priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  wb_we,
  output logic [NREG-1:0]       wb_Dselect,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_src
);

  logic                  w_full0, w_full1;
  logic [REG_ADDR_W-1:0] w_rd0, w_rd1;
  logic [DATA_W-1:0]     w_data0, w_data1;
  logic                  w_gnt0, w_gnt1;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0]     w_sel_data;

  logic                  r_we;
  logic [NREG-1:0]       r_dsel;
  logic [DATA_W-1:0]     r_data;
  logic                  r_src;

  rf_wb_buf u_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (req0_valid),
    .i_rd    (req0_rd),
    .i_data  (req0_data),
    .i_grant (w_gnt0),
    .o_ready (req0_ready),
    .o_full  (w_full0),
    .o_rd    (w_rd0),
    .o_data  (w_data0)
  );

  rf_wb_buf u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (req1_valid),
    .i_rd    (req1_rd),
    .i_data  (req1_data),
    .i_grant (w_gnt1),
    .o_ready (req1_ready),
    .o_full  (w_full1),
    .o_rd    (w_rd1),
    .o_data  (w_data1)
  );

`ifdef RF_WB_ARB_RR_EN
  logic r_ptr;

  // Pointer names the preferred port; it only matters when both are full
  always_comb begin
    w_gnt0 = w_full0 && (!w_full1 || !r_ptr);
    w_gnt1 = w_full1 && (!w_full0 ||  r_ptr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_ptr <= w_gnt0;
    end
  end
`else
  always_comb begin
    w_gnt0 = w_full0;
    w_gnt1 = w_full1 && !w_full0;
  end
`endif

  always_comb begin
    w_sel_rd   = w_gnt1 ? w_rd1   : w_rd0;
    w_sel_data = w_gnt1 ? w_data1 : w_data0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_dsel <= '0;
      r_data <= '0;
      r_src  <= PORT_ALU;
    end else if (w_gnt0 || w_gnt1) begin
      r_we   <= (w_sel_rd != '0);
      r_dsel <= rd_onehot(w_sel_rd);
      r_data <= w_sel_data;
      r_src  <= w_gnt1 ? PORT_LD : PORT_ALU;
    end else begin
      r_we   <= 1'b0;
      r_dsel <= '0;
    end
  end

  assign wb_we      = r_we;
  assign wb_Dselect = r_dsel;
  assign wb_data    = r_data;
  assign wb_src     = r_src;

endmodule

`default_nettype wire
